// File: rtl/x_sz_pkg.sv
// Shared types and width helpers for the bytelane downsizer.
// Payload layout, MSB to LSB: {DST_ID, SRC_ID, ..., ADDR, ..., STRB, DATA}.
package x_sz_pkg;

  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} x_sz_st_e;

  function automatic int hdr_w(int pi, int di);
    return pi - di - di / 8;
  endfunction

  function automatic int po_w(int pi, int di, int dout);
    return hdr_w(pi, di) + dout + dout / 8;
  endfunction

  function automatic int adr_lsb(int pi, int m, int n, int a);
    return pi - $clog2(n) - $clog2(m) - a;
  endfunction

endpackage

// File: rtl/x_sz_lane_find.sv
// Finds the lowest set mask bit above (or, with incl, at) the current index.
// none is raised when no such bit exists.
module x_sz_lane_find #(
  parameter int R = 2
) (
  input  logic [R-1:0]         mask,
  input  logic [$clog2(R)-1:0] cur,
  input  logic                 incl,
  output logic [$clog2(R)-1:0] nxt,
  output logic                 none
);

  localparam int KW = $clog2(R);

  // Descending scan so the lowest qualifying index is written last.
  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int i = R - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
        nxt  = i[KW-1:0];
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/x_sz_split.sv
// Sequential bytelane downsizer: serializes one wide beat into the narrow
// chunks that carry strobes, rewriting the chunk-select address bits per beat.
module x_sz_split
  import x_sz_pkg::*;
#(
  parameter int M  = 3,
  parameter int N  = 2,
  parameter int A  = 19,
  parameter int DI = 64,
  parameter int DO = 32,
  // Default sized so the header holds exactly DST, SRC and ADDR.
  parameter int PI = 94
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_vld,
  output logic                         s_rdy,
  input  logic [PI-1:0]                pld_s,
  output logic                         m_vld,
  input  logic                         m_rdy,
  output logic [po_w(PI, DI, DO)-1:0]  pld_m,
  output logic                         m_last
);

  localparam int PO      = po_w(PI, DI, DO);
  localparam int HW      = hdr_w(PI, DI);
  localparam int SI      = DI / 8;
  localparam int SO      = DO / 8;
  localparam int R       = DI / DO;
  localparam int KW      = $clog2(R);
  localparam int LSO     = $clog2(SO);
  localparam int ADR_LSB = adr_lsb(PI, M, N, A);
  localparam int ADR_H   = ADR_LSB - DI - SI;

  x_sz_st_e         state_reg, state_next;
  logic [PI-1:0]    pld_reg;
  logic [KW-1:0]    k_reg;
  logic             m_vld_reg;
  logic             m_last_reg;
  logic [PO-1:0]    pld_m_reg;

  logic [R-1:0]     mask_s, mask_r;
  logic [KW-1:0]    find_k, nxt_k, adr_k, first_k;
  logic             none_s, none_r, first_last, nxt_last;
  logic             accept, advance;

  generate
    for (genvar gi = 0; gi < R; gi++) begin : g_mask
      assign mask_s[gi] = |pld_s[DI + gi*SO +: SO];
      assign mask_r[gi] = |pld_reg[DI + gi*SO +: SO];
    end
  endgenerate

  x_sz_lane_find #(.R(R)) u_find_first (
    .mask (mask_s),
    .cur  ('0),
    .incl (1'b1),
    .nxt  (find_k),
    .none (none_s)
  );

  x_sz_lane_find #(.R(R)) u_find_next (
    .mask (mask_r),
    .cur  (k_reg),
    .incl (1'b0),
    .nxt  (nxt_k),
    .none (none_r)
  );

  function automatic logic any_above(input logic [R-1:0] mask, input logic [KW-1:0] j);
    logic found;
    found = 1'b0;
    for (int i = 0; i < R; i++) begin
      if (mask[i] && (i > int'(j))) found = 1'b1;
    end
    return found;
  endfunction

  // Header copy with the chunk index forced into the address; byte offset
  // below the chunk survives only on the first emitted beat.
  function automatic logic [PO-1:0] make_beat(input logic [PI-1:0] w,
                                               input logic [KW-1:0] k,
                                               input logic first);
    logic [HW-1:0] hdr;
    hdr = w[PI-1 -: HW];
    for (int i = 0; i < KW; i++) hdr[ADR_H + LSO + i] = k[i];
    if (!first) begin
      for (int i = 0; i < LSO; i++) hdr[ADR_H + i] = 1'b0;
    end
    return {hdr, w[DI + int'(k)*SO +: SO], w[int'(k)*DO +: DO]};
  endfunction

  // An all-zero strobe emits the single chunk the address points at.
  assign adr_k      = pld_s[ADR_LSB + LSO +: KW];
  assign first_k    = none_s ? adr_k : find_k;
  assign first_last = none_s ? 1'b1 : !any_above(mask_s, find_k);
  assign nxt_last   = !any_above(mask_r, nxt_k);

  assign accept  = s_vld & s_rdy;
  assign advance = m_vld_reg & m_rdy;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SPLIT;
      SPLIT:   if (advance && m_last_reg && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_rdy = 1'b0;
    if (!rst) begin
      case (state_reg)
        IDLE:    s_rdy = 1'b1;
        SPLIT:   s_rdy = m_last_reg & m_rdy;
        default: s_rdy = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pld_reg    <= '0;
      k_reg      <= '0;
      m_vld_reg  <= 1'b0;
      m_last_reg <= 1'b0;
      pld_m_reg  <= '0;
    end else if (accept) begin
      pld_reg    <= pld_s;
      k_reg      <= first_k;
      pld_m_reg  <= make_beat(pld_s, first_k, 1'b1);
      m_last_reg <= first_last;
      m_vld_reg  <= 1'b1;
    end else if (advance) begin
      if (m_last_reg) begin
        m_vld_reg  <= 1'b0;
        m_last_reg <= 1'b0;
      end else if (!none_r) begin
        k_reg      <= nxt_k;
        pld_m_reg  <= make_beat(pld_reg, nxt_k, 1'b0);
        m_last_reg <= nxt_last;
      end
    end
  end

  assign m_vld  = m_vld_reg;
  assign m_last = m_last_reg;
  assign pld_m  = pld_m_reg;

endmodule
